// File: rtl/mem_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_stage_if : execute-side, data-bus and write-back signals of     |
// |                the memory-access stage                              |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
interface mem_stage_if #(
    parameter int ADDR_W = 32
);
    logic              ex_valid_i;
    logic              ex_ready_o;
    logic [31:0]       instr_i;
    logic [31:0]       pc_i;
    logic [31:0]       result_i;
    logic [31:0]       rs2_i;
    logic              data_req_o;
    logic              data_we_o;
    logic [3:0]        data_be_o;
    logic [ADDR_W-1:0] data_addr_o;
    logic [31:0]       data_wdata_o;
    logic              data_gnt_i;
    logic              data_rvalid_i;
    logic [31:0]       data_rdata_i;
    logic              wb_valid_o;
    logic              wb_we_o;
    logic [4:0]        wb_rd_o;
    logic [31:0]       wb_data_o;
    logic              misaligned_o;

    modport master (
        input  ex_valid_i, instr_i, pc_i, result_i, rs2_i,
        input  data_gnt_i, data_rvalid_i, data_rdata_i,
        output ex_ready_o, data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        output wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, misaligned_o
    );

    modport slave (
        output ex_valid_i, instr_i, pc_i, result_i, rs2_i,
        output data_gnt_i, data_rvalid_i, data_rdata_i,
        input  ex_ready_o, data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        input  wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, misaligned_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_stage : memory-access stage; loads/stores on a req/gnt/rvalid   |
// |             bus with lane steering, registered write-back result    |
// | Revision  : 1.0                                                     |
// +--------------------------------------------------------------------+
module mem_stage #(
    parameter int ADDR_W = 32
) (
    input  logic       clk,
    input  logic       rst_i,
    mem_stage_if.master bus
);

    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [6:0]        w_opcode;
    logic [4:0]        w_rd;
    logic [2:0]        w_funct3;
    logic [1:0]        w_off;
    logic              w_accept;
    logic              w_is_load;
    logic              w_is_store;
    logic              w_legal_f3;
    logic              w_misaligned;
    logic              w_mem_bad;
    logic              w_mem_go;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_shifted;
    logic [31:0]       w_load_data;
    logic              w_unused_bits;

    logic              r_req;
    logic              r_we;
    logic [3:0]        r_be;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_wb_valid;
    logic              r_wb_we;
    logic [4:0]        r_wb_rd;
    logic [31:0]       r_wb_data;
    logic              r_misaligned;
    logic [2:0]        r_funct3;
    logic [1:0]        r_off;

    assign w_opcode   = bus.instr_i[6:0];
    assign w_rd       = bus.instr_i[11:7];
    assign w_funct3   = bus.instr_i[14:12];
    assign w_off      = bus.result_i[1:0];
    assign w_accept   = bus.ex_valid_i && (r_state == IDLE);
    assign w_is_load  = (w_opcode == c_OPC_LOAD);
    assign w_is_store = (w_opcode == c_OPC_STORE);

    // Loads allow signed/unsigned byte and half plus word; stores only b/h/w.
    assign w_legal_f3 = w_is_load ? ((w_funct3 != 3'b011) && (w_funct3[2:1] != 2'b11))
                                  : ((w_funct3[2] == 1'b0) && (w_funct3[1:0] != 2'b11));

    assign w_misaligned = ((w_funct3[1:0] == 2'b01) && w_off[0]) ||
                          ((w_funct3[1:0] == 2'b10) && (w_off != 2'b00));
    assign w_mem_bad    = !w_legal_f3 || w_misaligned;
    assign w_mem_go     = w_accept && (w_is_load || w_is_store) && !w_mem_bad;

    assign w_unused_bits = ^bus.instr_i[31:15];

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = bus.rs2_i;
        case (w_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{bus.rs2_i[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {w_off[1], 1'b0};
                w_wdata = {2{bus.rs2_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_shifted = bus.data_rdata_i >> {r_off, 3'b000};

    always_comb begin
        w_load_data = w_shifted;
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_load_data = {24'h000000, w_shifted[7:0]};
            3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_load_data = {16'h0000, w_shifted[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_mem_go) w_state_nxt = REQ;
            REQ:     if (bus.data_gnt_i) w_state_nxt = r_we ? IDLE : WAIT;
            WAIT:    if (bus.data_rvalid_i) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_be         <= 4'h0;
            r_addr       <= '0;
            r_wdata      <= 32'h0;
            r_wb_valid   <= 1'b0;
            r_wb_we      <= 1'b0;
            r_wb_rd      <= 5'd0;
            r_wb_data    <= 32'h0;
            r_misaligned <= 1'b0;
            r_funct3     <= 3'd0;
            r_off        <= 2'd0;
        end else begin
            r_wb_valid   <= 1'b0;
            r_misaligned <= 1'b0;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_wb_rd  <= w_rd;
                    r_funct3 <= w_funct3;
                    r_off    <= w_off;
                    if (w_is_load || w_is_store) begin
                        if (w_mem_bad) begin
                            r_wb_valid   <= 1'b1;
                            r_wb_we      <= 1'b0;
                            r_misaligned <= 1'b1;
                        end else begin
                            r_req   <= 1'b1;
                            r_we    <= w_is_store;
                            r_be    <= w_be;
                            r_addr  <= {bus.result_i[ADDR_W-1:2], 2'b00};
                            r_wdata <= w_wdata;
                        end
                    end else begin
                        r_wb_valid <= 1'b1;
                        case (w_opcode)
                            c_OPC_JAL, c_OPC_JALR: begin
                                r_wb_data <= bus.pc_i + 32'd4;
                                r_wb_we   <= (w_rd != 5'd0);
                            end
                            c_OPC_LUI, c_OPC_AUIPC, c_OPC_OP_IMM, c_OPC_OP: begin
                                r_wb_data <= bus.result_i;
                                r_wb_we   <= (w_rd != 5'd0);
                            end
                            default: r_wb_we <= 1'b0;
                        endcase
                    end
                end
                REQ: if (bus.data_gnt_i) begin
                    r_req <= 1'b0;
                    if (r_we) begin
                        r_wb_valid <= 1'b1;
                        r_wb_we    <= 1'b0;
                    end
                end
                WAIT: if (bus.data_rvalid_i) begin
                    r_wb_valid <= 1'b1;
                    r_wb_data  <= w_load_data;
                    r_wb_we    <= (r_wb_rd != 5'd0);
                end
                default: ;
            endcase
        end
    end

    assign bus.ex_ready_o   = (r_state == IDLE);
    assign bus.data_req_o   = r_req;
    assign bus.data_we_o    = r_we;
    assign bus.data_be_o    = r_be;
    assign bus.data_addr_o  = r_addr;
    assign bus.data_wdata_o = r_wdata;
    assign bus.wb_valid_o   = r_wb_valid;
    assign bus.wb_we_o      = r_wb_we;
    assign bus.wb_rd_o      = r_wb_rd;
    assign bus.wb_data_o    = r_wb_data;
    assign bus.misaligned_o = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_stage : table vectors, hand sequences and random ops checked |
// |                against a byte-level reference model                  |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
module tb_mem_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_stage_if #(.ADDR_W(32)) bus ();
    mem_stage #(.ADDR_W(32)) dut (.clk(clk), .rst_i(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          lat;
        int          req;
        bit          mis;
        bit          we;
        bit          dchk;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          st;
    } exp_t;

    typedef struct {
        int          lat;
        int          req;
        bit          mis;
        bit          we;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          st;
        bit          unstable;
        bit          busy_ready;
        bit          ready_acc;
        bit          after_wb;
    } obs_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] res;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          gd;
        int          rvd;
        exp_t        e;
    } vec_t;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd, input logic [2:0] f3);
        return {17'h0, f3, rd, opc};
    endfunction

    // Reference: byte-oriented arithmetic on sizes/offsets, latency from handshake counts.
    function automatic exp_t model(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] res,
                                   input logic [31:0] rs2, input logic [31:0] rdata, input int gd, input int rvd);
        exp_t        e;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] m;
        logic [31:0] v;
        int          nb;
        int          off;
        bit          legal;
        opc = instr[6:0];
        rd  = instr[11:7];
        f3  = instr[14:12];
        e   = '{lat: 1, req: 0, mis: 1'b0, we: 1'b0, dchk: 1'b0, data: 32'h0, rd: rd,
                addr: 32'h0, be: 4'h0, wdata: 32'h0, st: 1'b0};
        if (opc == 7'h03 || opc == 7'h23) begin
            nb    = 1 << f3[1:0];
            off   = int'(res % 4);
            legal = (opc == 7'h03) ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
            if (!legal || (res % nb) != 0) begin
                e.mis = 1'b1;
            end else begin
                e.req  = gd + 1;
                e.addr = res & ~32'h3;
                e.be   = 4'(((1 << nb) - 1) << off);
                for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = rs2[8*(i % nb) +: 8];
                if (opc == 7'h23) begin
                    e.st  = 1'b1;
                    e.lat = gd + 2;
                end else begin
                    e.lat = gd + rvd + 3;
                    m = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
                    v = (rdata >> (8 * off)) & m;
                    if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~m;
                    e.data = v;
                    e.dchk = 1'b1;
                    e.we   = (rd != 5'd0);
                end
            end
        end else if (opc == 7'h6F || opc == 7'h67) begin
            e.data = pc + 32'd4;
            e.dchk = 1'b1;
            e.we   = (rd != 5'd0);
        end else if (opc inside {7'h37, 7'h17, 7'h13, 7'h33}) begin
            e.data = res;
            e.dchk = 1'b1;
            e.we   = (rd != 5'd0);
        end
        return e;
    endfunction

    task automatic run_op(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] res,
                          input logic [31:0] rs2, input logic [31:0] rdata, input int gd, input int rvd,
                          output obs_t o);
        bit granted;
        int rvc;
        o = '{default: '0};
        granted = 1'b0;
        rvc = 0;
        @(negedge clk);
        o.ready_acc           = bus.ex_ready_o;
        bus.ex_valid_i        = 1'b1;
        bus.instr_i           = instr;
        bus.pc_i              = pc;
        bus.result_i          = res;
        bus.rs2_i             = rs2;
        bus.data_gnt_i        = 1'($urandom);
        bus.data_rvalid_i     = 1'($urandom);
        bus.data_rdata_i      = $urandom;
        for (int cyc = 1; cyc <= 40 && o.lat == 0; cyc++) begin
            @(negedge clk);
            bus.ex_valid_i    = 1'b0;
            bus.instr_i       = $urandom;
            bus.pc_i          = $urandom;
            bus.result_i      = $urandom;
            bus.rs2_i         = $urandom;
            bus.data_gnt_i    = 1'b0;
            bus.data_rvalid_i = 1'b0;
            bus.data_rdata_i  = $urandom;
            if (bus.wb_valid_o) begin
                o.lat  = cyc;
                o.we   = bus.wb_we_o;
                o.mis  = bus.misaligned_o;
                o.data = bus.wb_data_o;
                o.rd   = bus.wb_rd_o;
            end else if (bus.data_req_o) begin
                if (bus.ex_ready_o) o.busy_ready = 1'b1;
                if (o.req == 0) begin
                    o.addr  = bus.data_addr_o;
                    o.be    = bus.data_be_o;
                    o.wdata = bus.data_wdata_o;
                    o.st    = bus.data_we_o;
                end else if (o.addr != bus.data_addr_o || o.be != bus.data_be_o ||
                             o.wdata != bus.data_wdata_o || o.st != bus.data_we_o) begin
                    o.unstable = 1'b1;
                end
                o.req++;
                bus.data_rvalid_i = 1'($urandom);
                if (o.req > gd) begin
                    bus.data_gnt_i = 1'b1;
                    granted = 1'b1;
                end
            end else if (granted) begin
                if (bus.ex_ready_o) o.busy_ready = 1'b1;
                if (rvc == rvd) begin
                    bus.data_rvalid_i = 1'b1;
                    bus.data_rdata_i  = rdata;
                end else begin
                    bus.data_gnt_i = 1'($urandom);
                end
                rvc++;
            end
        end
        @(negedge clk);
        o.after_wb        = bus.wb_valid_o;
        bus.data_gnt_i    = 1'b0;
        bus.data_rvalid_i = 1'b0;
    endtask

    task automatic check_op(input string tag, input obs_t o, input exp_t e);
        chk(o.ready_acc, {tag, " ready_at_accept"}, 32'(o.ready_acc), 32'd1);
        chk(o.lat == e.lat, {tag, " latency"}, 32'(o.lat), 32'(e.lat));
        chk(o.req == e.req, {tag, " req_cycles"}, 32'(o.req), 32'(e.req));
        chk(o.mis == e.mis, {tag, " misaligned"}, 32'(o.mis), 32'(e.mis));
        chk(o.we == e.we, {tag, " wb_we"}, 32'(o.we), 32'(e.we));
        chk(!o.after_wb, {tag, " wb_pulse_len"}, 32'(o.after_wb), 32'd0);
        if (e.dchk) chk(o.data == e.data, {tag, " wb_data"}, o.data, e.data);
        if (e.we)   chk(o.rd == e.rd, {tag, " wb_rd"}, 32'(o.rd), 32'(e.rd));
        if (e.req != 0) begin
            chk(o.addr == e.addr, {tag, " addr"}, o.addr, e.addr);
            chk(o.be == e.be, {tag, " be"}, 32'(o.be), 32'(e.be));
            chk(o.st == e.st, {tag, " data_we"}, 32'(o.st), 32'(e.st));
            chk(!o.unstable, {tag, " req_stable"}, 32'(o.unstable), 32'd0);
            chk(!o.busy_ready, {tag, " ready_low_busy"}, 32'(o.busy_ready), 32'd0);
            if (e.st) chk(o.wdata == e.wdata, {tag, " wdata"}, o.wdata, e.wdata);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    vec_t        tbl[17];
    obs_t        o;
    exp_t        e;
    logic [31:0] instr;
    logic [31:0] res;
    logic [2:0]  f3;
    logic [6:0]  opc;
    logic [6:0]  opcs[10];

    initial begin
        tbl[0]  = '{mk(7'h13, 5'd5, 3'd0), 32'h0, 32'h1234, 32'h0, 32'h0, 0, 0,
                    '{1, 0, 1'b0, 1'b1, 1'b1, 32'h1234, 5'd5, 32'h0, 4'h0, 32'h0, 1'b0}};
        tbl[1]  = '{mk(7'h6F, 5'd1, 3'd0), 32'h100, 32'h0, 32'h0, 32'h0, 0, 0,
                    '{1, 0, 1'b0, 1'b1, 1'b1, 32'h104, 5'd1, 32'h0, 4'h0, 32'h0, 1'b0}};
        tbl[2]  = '{mk(7'h23, 5'd0, 3'd0), 32'h0, 32'h1003, 32'hAB, 32'h0, 2, 0,
                    '{4, 3, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h1000, 4'h8, 32'hABABABAB, 1'b1}};
        tbl[3]  = '{mk(7'h03, 5'd7, 3'd0), 32'h0, 32'h40000003, 32'h0, 32'h80FF7F01, 0, 0,
                    '{3, 1, 1'b0, 1'b1, 1'b1, 32'hFFFFFF80, 5'd7, 32'h40000000, 4'h8, 32'h0, 1'b0}};
        tbl[4]  = '{mk(7'h03, 5'd8, 3'd4), 32'h0, 32'h40000003, 32'h0, 32'h80FF7F01, 0, 0,
                    '{3, 1, 1'b0, 1'b1, 1'b1, 32'h00000080, 5'd8, 32'h40000000, 4'h8, 32'h0, 1'b0}};
        tbl[5]  = '{mk(7'h03, 5'd9, 3'd1), 32'h0, 32'h40000002, 32'h0, 32'h80FF7F01, 0, 0,
                    '{3, 1, 1'b0, 1'b1, 1'b1, 32'hFFFF80FF, 5'd9, 32'h40000000, 4'hC, 32'h0, 1'b0}};
        tbl[6]  = '{mk(7'h03, 5'd10, 3'd2), 32'h0, 32'h40000000, 32'h0, 32'h80FF7F01, 0, 0,
                    '{3, 1, 1'b0, 1'b1, 1'b1, 32'h80FF7F01, 5'd10, 32'h40000000, 4'hF, 32'h0, 1'b0}};
        tbl[7]  = '{mk(7'h03, 5'd11, 3'd2), 32'h0, 32'h2002, 32'h0, 32'h0, 0, 0,
                    '{1, 0, 1'b1, 1'b0, 1'b0, 32'h0, 5'd11, 32'h0, 4'h0, 32'h0, 1'b0}};
        tbl[8]  = '{mk(7'h03, 5'd12, 3'd3), 32'h0, 32'h3000, 32'h0, 32'h0, 0, 0,
                    '{1, 0, 1'b1, 1'b0, 1'b0, 32'h0, 5'd12, 32'h0, 4'h0, 32'h0, 1'b0}};
        tbl[9]  = '{mk(7'h03, 5'd0, 3'd2), 32'h0, 32'h10, 32'h0, 32'h5555, 0, 0,
                    '{3, 1, 1'b0, 1'b0, 1'b1, 32'h5555, 5'd0, 32'h10, 4'hF, 32'h0, 1'b0}};
        tbl[10] = '{mk(7'h67, 5'd0, 3'd0), 32'hFFFFFFFC, 32'h0, 32'h0, 32'h0, 0, 0,
                    '{1, 0, 1'b0, 1'b0, 1'b1, 32'h0, 5'd0, 32'h0, 4'h0, 32'h0, 1'b0}};
        tbl[11] = '{mk(7'h63, 5'd3, 3'd1), 32'h0, 32'h77, 32'h0, 32'h0, 0, 0,
                    '{1, 0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd3, 32'h0, 4'h0, 32'h0, 1'b0}};
        tbl[12] = '{mk(7'h03, 5'd13, 3'd5), 32'h0, 32'h42, 32'h0, 32'h80FF7F01, 1, 2,
                    '{6, 2, 1'b0, 1'b1, 1'b1, 32'h000080FF, 5'd13, 32'h40, 4'hC, 32'h0, 1'b0}};
        tbl[13] = '{mk(7'h23, 5'd0, 3'd2), 32'h0, 32'h2004, 32'hDEADBEEF, 32'h0, 0, 0,
                    '{2, 1, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h2004, 4'hF, 32'hDEADBEEF, 1'b1}};
        tbl[14] = '{mk(7'h23, 5'd0, 3'd1), 32'h0, 32'h2006, 32'h1234ABCD, 32'h0, 1, 0,
                    '{3, 2, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h2004, 4'hC, 32'hABCDABCD, 1'b1}};
        tbl[15] = '{mk(7'h23, 5'd0, 3'd3), 32'h0, 32'h2000, 32'h0, 32'h0, 0, 0,
                    '{1, 0, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0, 4'h0, 32'h0, 1'b0}};
        tbl[16] = '{mk(7'h37, 5'd31, 3'd0), 32'h0, 32'hABCDE000, 32'h0, 32'h0, 0, 0,
                    '{1, 0, 1'b0, 1'b1, 1'b1, 32'hABCDE000, 5'd31, 32'h0, 4'h0, 32'h0, 1'b0}};
        opcs = '{7'h03, 7'h23, 7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h7F};

        bus.ex_valid_i    = 1'b0;
        bus.instr_i       = 32'h0;
        bus.pc_i          = 32'h0;
        bus.result_i      = 32'h0;
        bus.rs2_i         = 32'h0;
        bus.data_gnt_i    = 1'b0;
        bus.data_rvalid_i = 1'b0;
        bus.data_rdata_i  = 32'h0;

        repeat (2) @(negedge clk);
        chk(bus.ex_ready_o == 1'b1, "rst ex_ready", 32'(bus.ex_ready_o), 32'd1);
        chk(bus.data_req_o == 1'b0, "rst data_req", 32'(bus.data_req_o), 32'd0);
        chk(bus.data_we_o == 1'b0, "rst data_we", 32'(bus.data_we_o), 32'd0);
        chk(bus.data_be_o == 4'h0, "rst data_be", 32'(bus.data_be_o), 32'd0);
        chk(bus.data_addr_o == 32'h0, "rst data_addr", bus.data_addr_o, 32'd0);
        chk(bus.data_wdata_o == 32'h0, "rst data_wdata", bus.data_wdata_o, 32'd0);
        chk(bus.wb_valid_o == 1'b0, "rst wb_valid", 32'(bus.wb_valid_o), 32'd0);
        chk(bus.wb_we_o == 1'b0, "rst wb_we", 32'(bus.wb_we_o), 32'd0);
        chk(bus.wb_rd_o == 5'd0, "rst wb_rd", 32'(bus.wb_rd_o), 32'd0);
        chk(bus.wb_data_o == 32'h0, "rst wb_data", bus.wb_data_o, 32'd0);
        chk(bus.misaligned_o == 1'b0, "rst misaligned", 32'(bus.misaligned_o), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            run_op(tbl[i].instr, tbl[i].pc, tbl[i].res, tbl[i].rs2, tbl[i].rdata, tbl[i].gd, tbl[i].rvd, o);
            check_op($sformatf("vec%0d", i), o, tbl[i].e);
        end

        // Back-to-back ALU accepts on consecutive cycles.
        @(negedge clk);
        bus.ex_valid_i = 1'b1;
        bus.instr_i    = mk(7'h13, 5'd2, 3'd0);
        bus.result_i   = 32'h1111_2222;
        @(negedge clk);
        chk(bus.wb_valid_o == 1'b1, "b2b first valid", 32'(bus.wb_valid_o), 32'd1);
        chk(bus.wb_data_o == 32'h1111_2222, "b2b first data", bus.wb_data_o, 32'h1111_2222);
        chk(bus.ex_ready_o == 1'b1, "b2b ready", 32'(bus.ex_ready_o), 32'd1);
        bus.instr_i  = mk(7'h33, 5'd3, 3'd0);
        bus.result_i = 32'h3333_4444;
        @(negedge clk);
        chk(bus.wb_valid_o == 1'b1, "b2b second valid", 32'(bus.wb_valid_o), 32'd1);
        chk(bus.wb_data_o == 32'h3333_4444, "b2b second data", bus.wb_data_o, 32'h3333_4444);
        chk(bus.wb_rd_o == 5'd3, "b2b second rd", 32'(bus.wb_rd_o), 32'd3);
        bus.ex_valid_i = 1'b0;
        @(negedge clk);
        chk(bus.wb_valid_o == 1'b0, "b2b idle valid", 32'(bus.wb_valid_o), 32'd0);

        // Reset while a load waits for rvalid; the late rvalid must be dropped.
        bus.ex_valid_i = 1'b1;
        bus.instr_i    = mk(7'h03, 5'd6, 3'd2);
        bus.result_i   = 32'h500;
        @(negedge clk);
        bus.ex_valid_i = 1'b0;
        chk(bus.data_req_o == 1'b1, "rstmid req", 32'(bus.data_req_o), 32'd1);
        bus.data_gnt_i = 1'b1;
        @(negedge clk);
        bus.data_gnt_i = 1'b0;
        chk(bus.ex_ready_o == 1'b0, "rstmid wait ready", 32'(bus.ex_ready_o), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk(bus.data_req_o == 1'b0, "rstmid req after", 32'(bus.data_req_o), 32'd0);
        chk(bus.ex_ready_o == 1'b1, "rstmid ready after", 32'(bus.ex_ready_o), 32'd1);
        bus.data_rvalid_i = 1'b1;
        bus.data_rdata_i  = 32'hCAFE_F00D;
        @(negedge clk);
        bus.data_rvalid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk(bus.wb_valid_o == 1'b0, "rstmid wb_valid", 32'(bus.wb_valid_o), 32'd0);
            @(negedge clk);
        end

        for (int n = 0; n < 150; n++) begin
            opc   = opcs[$urandom_range(0, 9)];
            if ($urandom_range(0, 2) == 0) opc = ($urandom_range(0, 1) == 0) ? 7'h03 : 7'h23;
            f3    = 3'($urandom_range(0, 7));
            instr = mk(opc, 5'($urandom_range(0, 31)), f3);
            res   = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                case (f3[1:0])
                    2'b01:   res[0] = 1'b0;
                    2'b10:   res[1:0] = 2'b00;
                    default: ;
                endcase
            end
            begin
                logic [31:0] pc;
                logic [31:0] rs2;
                logic [31:0] rdata;
                int          gd;
                int          rvd;
                pc    = $urandom;
                rs2   = $urandom;
                rdata = $urandom;
                gd    = $urandom_range(0, 3);
                rvd   = $urandom_range(0, 3);
                e = model(instr, pc, res, rs2, rdata, gd, rvd);
                run_op(instr, pc, res, rs2, rdata, gd, rvd, o);
                check_op($sformatf("rnd%0d", n), o, e);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage between `executer` and register write-back. It takes one executed instruction per handshake and runs loads and stores on a req/gnt/rvalid data bus, with byte enables, byte-lane steering and sign/zero extension. It registers the write-back result, stalls the execute stage while a bus access is outstanding, and passes non-memory instructions through in one cycle.

## Interface
Parameters:
- `ADDR_W`, 32: data bus address width; address bits 1:0 are never driven on the bus.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_i`  in  1: synchronous, active-high reset.
- `ex_valid_i`  in  1: execute stage presents an instruction.
- `ex_ready_o`  out  1: stage can accept an instruction; high only in IDLE.
- `instr_i`  in  32: instruction word (opcode [6:0], rd [11:7], funct3 [14:12]).
- `pc_i`  in  32: PC of the instruction.
- `result_i`  in  32: ALU result, which is the effective address for LOAD/STORE.
- `rs2_i`  in  32: store data.
- `data_req_o`  out  1: bus request.
- `data_we_o`  out  1: 1 means store.
- `data_be_o`  out  4: byte enables.
- `data_addr_o`  out  ADDR_W: word-aligned address, {addr[ADDR_W-1:2],2'b00}.
- `data_wdata_o`  out  32: lane-replicated store data.
- `data_gnt_i`  in  1: bus accepts the request in this cycle.
- `data_rvalid_i`  in  1: read data valid.
- `data_rdata_i`  in  32: read data.
- `wb_valid_o`  out  1: one-cycle pulse; write-back fields are valid.
- `wb_we_o`  out  1: register write enable; forced to 0 when rd is 0.
- `wb_rd_o`  out  5: destination register.
- `wb_data_o`  out  32: write-back value.
- `misaligned_o`  out  1: one-cycle pulse alongside `wb_valid_o` for a misaligned or illegal-funct3 access.

## Operation
- FSM states: IDLE, REQ, WAIT.
- Accept: an instruction is accepted when `ex_valid_i` and `ex_ready_o` are both high. On accept, latch instr, pc, result and rs2.
- Non-memory opcodes are handled in IDLE and the FSM stays in IDLE:
  - JAL/JALR: `wb_data_o` = pc+4 (mod 2^32), `wb_we_o` = (rd != 0).
  - LUI, AUIPC, IMM_REG_ALU, REG_REG_ALU: `wb_data_o` = result, `wb_we_o` = (rd != 0).
  - BRANCH, STORE-class opcodes not listed above, and unknown opcodes: `wb_we_o` = 0.
- LOAD/STORE legality: an access is misaligned when it is a halfword with addr[0]=1, or a word with addr[1:0] != 0. Legal load funct3 values are 000, 001, 010, 100, 101. Legal store funct3 values are 000, 001, 010.
- Misaligned or illegal access: no bus access. Next cycle `wb_valid_o` = 1, `wb_we_o` = 0 and `misaligned_o` = 1. The FSM stays in IDLE.
- Legal access: go to REQ and hold `data_req_o` = 1 with stable addr/we/be/wdata until `data_gnt_i` = 1.
  - Store: REQ → IDLE on gnt, and `wb_valid_o` = 1 with `wb_we_o` = 0 in the next cycle.
  - Load: REQ → WAIT on gnt. WAIT → IDLE on rvalid, and `wb_valid_o` is asserted in the next cycle.
- Byte enables:
  - Byte: 4'b0001 << addr[1:0].
  - Half: 4'b0011 << {addr[1],1'b0}.
  - Word: 4'b1111.
- Store data: byte is {4{rs2[7:0]}}, half is {2{rs2[15:0]}}, word is rs2.
- Load data: shift `data_rdata_i` right by 8*addr[1:0], then apply:
  - LB: sign-extend bit 7.
  - LBU: zero-extend bit 7.
  - LH: sign-extend bit 15.
  - LHU: zero-extend bit 15.
  - LW: unchanged.
- `data_rvalid_i` outside WAIT is ignored. `data_gnt_i` outside REQ is ignored.

## Timing
- Reset values: `ex_ready_o` = 1 (IDLE). `data_req_o`, `data_we_o`, `wb_valid_o`, `wb_we_o` and `misaligned_o` are 0. `data_be_o`, `wb_rd_o`, `data_addr_o`, `data_wdata_o` and `wb_data_o` are 0.
- Reset during REQ or WAIT: the access is abandoned and the FSM returns to IDLE. `data_req_o` is 0 in the cycle after reset is sampled, and any later rvalid is ignored.
- All outputs are registered except `ex_ready_o`, which decodes the state. `data_req_o` is high exactly while in REQ.
- Latency is counted from the accept cycle N:
  - Non-memory and misaligned: `wb_valid_o` in cycle N+1, with back-to-back accepts every cycle.
  - Store with immediate gnt: `data_req_o` in N+1, `wb_valid_o` in N+2, next accept in N+2.
  - Load with gnt in N+1 and rvalid in N+2: `wb_valid_o` in N+3.
- Each wait cycle on gnt or rvalid adds one cycle. `ex_ready_o` is low throughout REQ and WAIT.
- `wb_valid_o` lasts exactly one cycle per accepted instruction; the write-back stage never back-pressures.

## Test plan
- Reset mid-load: assert `rst_i` while in WAIT, then pulse rvalid → `wb_valid_o` stays 0, `data_req_o` is 0 and `ex_ready_o` is 1.
- ALU op: ADDI rd=5 with result=0x1234 → next cycle `wb_valid_o` = 1, `wb_rd_o` = 5, `wb_data_o` = 0x1234, `wb_we_o` = 1. JAL rd=1 with pc=0x100 → `wb_data_o` = 0x104.
- SB to address 0x1003 with rs2=0xAB, gnt delayed 2 cycles → `data_req_o` held 3 cycles, addr 0x1000, be 4'b1000, wdata 0xABABABAB. `wb_valid_o` follows gnt by one cycle with `wb_we_o` = 0.
- Load lane steering with rdata=0x80FF7F01:
  - LB at offset 3 → 0xFFFFFF80.
  - LBU at offset 3 → 0x00000080.
  - LH at offset 2 → 0xFFFF80FF.
  - LW at offset 0 → 0x80FF7F01.
- LW at address 0x2002 → no `data_req_o`, then `wb_valid_o` = 1, `misaligned_o` = 1, `wb_we_o` = 0 at N+1. A load with funct3=011 behaves the same way.
- LW with rd=0 → `wb_we_o` = 0.
